// File: rtl/display_scan.sv
// display_scan
//   Converts an 8-bit binary value to three BCD digits with a shift-and-add-3
//   (double dabble) FSM, then time-multiplexes the digits onto a common
//   active-low 7-segment display.
//
// Parameters
//   REFRESH_DIV : clk cycles each digit stays lit before the scan advances (>= 2)
//   BLANK_LZ    : 1 = blank leading zeros, 0 = always show all three digits
//
// Ports
//   clk       : system clock, all registers update on the rising edge
//   rst       : synchronous active-low reset
//   value_in  : binary value 0..255, sampled only on an accepted load
//   load      : single-cycle request to convert value_in
//   busy      : high while a conversion is in progress
//   an        : active-low one-hot digit enable (bit 0 units, 1 tens, 2 hundreds)
//   display   : active-low segments, display[0] = a ... display[6] = g
//   dbg_state : current conversion FSM state (0 IDLE, 1 CONVERT, 2 LATCH)
//
// Handshake: load is a one-cycle pulse that is accepted only while the FSM is
// in IDLE (busy low and not the LATCH cycle); any other load is dropped, never
// queued. busy rises at the accepting edge and falls at the LATCH edge, when
// the new digits become visible.
module display_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value_in,
  input  logic       load,
  output logic       busy,
  output logic [2:0] an,
  output logic [0:6] display,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_LATCH   = 2'd2
  } state_t;

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  state_t        r_state;
  logic          r_busy;
  logic [7:0]    r_bin;
  logic [11:0]   r_bcd;
  logic [2:0]    r_bit_cnt;
  logic [3:0]    r_hun;
  logic [3:0]    r_ten;
  logic [3:0]    r_uni;
  logic [CW-1:0] r_refresh;
  logic [1:0]    r_idx;

  logic [3:0]    w_adj_u;
  logic [3:0]    w_adj_t;
  logic [3:0]    w_adj_h;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [0:6]    w_seg;

  // Add-3 correction applied to each nibble before the shift so that a
  // nibble of 5..9 carries correctly into the next decade after doubling.
  assign w_adj_u = (r_bcd[3:0]  >= 4'd5) ? r_bcd[3:0]  + 4'd3 : r_bcd[3:0];
  assign w_adj_t = (r_bcd[7:4]  >= 4'd5) ? r_bcd[7:4]  + 4'd3 : r_bcd[7:4];
  assign w_adj_h = (r_bcd[11:8] >= 4'd5) ? r_bcd[11:8] + 4'd3 : r_bcd[11:8];

  // Conversion FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_bin     <= 8'd0;
      r_bcd     <= 12'd0;
      r_bit_cnt <= 3'd0;
      r_hun     <= 4'd0;
      r_ten     <= 4'd0;
      r_uni     <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_bin     <= value_in;
            r_bcd     <= 12'd0;
            r_bit_cnt <= 3'd0;
            r_busy    <= 1'b1;
            r_state   <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          // {bcd, bin} shifted left by one after the nibble correction
          r_bcd     <= {w_adj_h[2:0], w_adj_t, w_adj_u, r_bin[7]};
          r_bin     <= {r_bin[6:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_state <= S_LATCH;
          end
        end
        S_LATCH: begin
          // Digits change only here, so the display never shows a partial result.
          r_hun   <= r_bcd[11:8];
          r_ten   <= r_bcd[7:4];
          r_uni   <= r_bcd[3:0];
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Scan counter runs free of the FSM; the digit index steps on each wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_refresh <= '0;
      r_idx     <= 2'd0;
    end else begin
      if (r_refresh == CW'(REFRESH_DIV - 1)) begin
        r_refresh <= '0;
        r_idx     <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      end else begin
        r_refresh <= r_refresh + CW'(1);
      end
    end
  end

  // Digit select and leading-zero blanking
  always_comb begin
    w_digit = r_uni;
    w_blank = 1'b0;
    an      = 3'b110;
    case (r_idx)
      2'd1: begin
        w_digit = r_ten;
        w_blank = BLANK_LZ && (r_hun == 4'd0) && (r_ten == 4'd0);
        an      = 3'b101;
      end
      2'd2: begin
        w_digit = r_hun;
        w_blank = BLANK_LZ && (r_hun == 4'd0);
        an      = 3'b011;
      end
      default: begin
        w_digit = r_uni;
        w_blank = 1'b0;
        an      = 3'b110;
      end
    endcase
  end

  // Segment decoder, order a..g, active-low; 10..15 cannot occur but decode dark.
  always_comb begin
    w_seg = 7'b1111111;
    case (w_digit)
      4'd0:    w_seg = 7'b0000001;
      4'd1:    w_seg = 7'b1001111;
      4'd2:    w_seg = 7'b0010010;
      4'd3:    w_seg = 7'b0000110;
      4'd4:    w_seg = 7'b1001100;
      4'd5:    w_seg = 7'b0100100;
      4'd6:    w_seg = 7'b0100000;
      4'd7:    w_seg = 7'b0001111;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0000100;
      default: w_seg = 7'b1111111;
    endcase
  end

  assign display   = w_blank ? 7'b1111111 : w_seg;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule
